div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 Port rst  input  1  reset; asynchronous, active-low.
REQ-003 Port signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU).
REQ-004 Port opdata1_i  input  32  dividend, sampled only on accept.
REQ-005 Port opdata2_i  input  32  divisor, sampled only on accept.
REQ-006 Port start_i  input  1  EX-stage request; held high by EX until ready_o seen.
REQ-007 Port annul_i  input  1  pipeline flush; abandons the current division.
REQ-008 Port result_o  output  64  {remainder[63:32], quotient[31:0]}, mapping to {hi, lo}.
REQ-009 Port ready_o  output  1  result_o valid; EX deasserts its stall request when high.

Function
REQ-010 Block SHALL implement FSM states FREE, BYZERO, ON, END; all outputs registered.
REQ-011 FREE: start_i=1 and annul_i=0 SHALL accept; divisor 0 -> BYZERO, else -> ON, with cnt=0 and operands captured.
REQ-012 FREE: start_i=0 or annul_i=1 SHALL remain FREE, ready_o=0, result_o=0.
REQ-013 BYZERO SHALL go to END next edge with result_o=0 and ready_o=1.
REQ-014 ON SHALL perform one restoring shift-subtract step per cycle on 32-bit magnitudes, incrementing a 6-bit cnt for 32 steps.
REQ-015 ON with cnt=32 SHALL load result_o, set ready_o=1, go to END.
REQ-016 Latency: ready_o SHALL rise on the 34th edge after the accepting edge (accept edge counts as 1); byzero case on the 2nd edge.
REQ-017 Signed mode: negative operands SHALL be negated before iterating; quotient negated iff operand signs differ; remainder takes dividend's sign.
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-019 END SHALL hold result_o and ready_o=1 while start_i=1; start_i=0 SHALL go to FREE with ready_o=0, result_o=0.
REQ-020 annul_i=1 in ON or END SHALL go to FREE next edge, ready_o=0, result_o=0; takes priority over every other transition.
REQ-021 start_i changes and operand changes during ON SHALL NOT affect the running division.

Reset
REQ-022 rst low SHALL immediately force FREE, cnt=0, ready_o=0, result_o=0, including mid-division.
REQ-023 First accept SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: signed_div_i honoured per REQ-017/018.
REQ-025 DIV_SIGNED_EN undefined: signed_div_i ignored, all divisions unsigned, no negation logic synthesised.

Structure
REQ-026 Shared defines SHALL hold state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11, plus DivResultReady/DivResultNotReady, DivStart/DivStop, ZeroWord.
REQ-027 Single module, no sub-module; iteration datapath is a 65-bit dividend/remainder shift register plus 33-bit subtractor.

Verification
REQ-028 Unsigned 7/2, start held -> ready_o rises after 34 edges, result_o=0x00000001_00000003.
REQ-029 Signed -7/2 (0xFFFFFFF9, 0x2) -> result_o=0xFFFFFFFF_FFFFFFFD; with DIV_SIGNED_EN undefined -> 0x00000001_7FFFFFFC.
REQ-030 Divisor 0, dividend 0x1234 -> ready_o high after 2 edges, result_o=0.
REQ-031 annul_i pulsed at step 10 of 0x64/0x7 -> FREE next edge, ready_o stays 0; new 0x64/0x7 request -> 0x00000002_0000000E after 34 edges.
REQ-032 rst low at step 20 -> ready_o=0, result_o=0 immediately; start_i low in END -> FREE, ready_o=0 next edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings and constants for the radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [5:0]  DivSteps          = 6'd32;

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit divider, one restoring shift-subtract step per cycle.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every division is unsigned.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output div_state_e  dbg_state_o
);

  // Handshake: EX holds start_i high until it sees ready_o; result_o stays valid
  // in END while start_i is high, and dropping start_i returns the unit to FREE.

  div_state_e  r_state;
  div_state_e  w_state_nxt;
  logic [5:0]  r_cnt;
  logic [64:0] r_dividend;
  logic [31:0] r_divisor;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic [32:0] w_diff;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_accept = (start_i == DivStart) && !annul_i;
  assign w_diff   = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_op1_mag = (signed_div_i && opdata1_i[31]) ? (ZeroWord - opdata1_i) : opdata1_i;
  assign w_op2_mag = (signed_div_i && opdata2_i[31]) ? (ZeroWord - opdata2_i) : opdata2_i;
  assign w_quot    = r_neg_q ? (ZeroWord - r_dividend[31:0])  : r_dividend[31:0];
  assign w_rem     = r_neg_r ? (ZeroWord - r_dividend[64:33]) : r_dividend[64:33];

  // Sign fix-up flags are latched with the operands so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == DivFree && w_accept) begin
      r_neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
      r_neg_r <= signed_div_i && opdata1_i[31];
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_div_i;
  assign w_op1_mag       = opdata1_i;
  assign w_op2_mag       = opdata2_i;
  assign w_quot          = r_dividend[31:0];
  assign w_rem           = r_dividend[64:33];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DivFree: begin
        if (w_accept) begin
          w_state_nxt = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
        end
      end
      DivByZero: w_state_nxt = DivEnd;
      DivOn: begin
        if (annul_i) begin
          w_state_nxt = DivFree;
        end else if (r_cnt == DivSteps) begin
          w_state_nxt = DivEnd;
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          w_state_nxt = DivFree;
        end
      end
      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 6'd0;
      r_dividend <= '0;
      r_divisor  <= ZeroWord;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
          if (w_accept) begin
            r_cnt      <= 6'd0;
            r_dividend <= {ZeroWord, w_op1_mag, 1'b0};
            r_divisor  <= w_op2_mag;
          end
        end
        DivByZero: begin
          r_result <= '0;
          r_ready  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            r_cnt    <= 6'd0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end else if (r_cnt != DivSteps) begin
            // A borrow means the trial subtraction failed: shift in a 0 quotient bit.
            if (w_diff[32]) begin
              r_dividend <= {r_dividend[63:0], 1'b0};
            end else begin
              r_dividend <= {w_diff[31:0], r_dividend[31:0], 1'b1};
            end
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_cnt    <= 6'd0;
            r_result <= {w_rem, w_quot};
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (annul_i || start_i == DivStop) begin
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
        end
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random divisions against an arithmetic model.
module tb_div;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  div_state_e  dbg_state_o;

  int n_assert = 0;
  int n_fail   = 0;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit integer division truncates toward zero and the remainder
  // takes the dividend's sign, which is exactly the required signed behaviour.
  function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic sg);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic   use_s;
`ifdef DIV_SIGNED_EN
    use_s = sg;
`else
    use_s = 1'b0 & sg;
`endif
    if (b == 32'd0) return 64'd0;
    if (use_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one division with start held; optionally scrambles operands/start while it runs.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp, input bit scramble);
    int n;
    int lat;
    n   = 0;
    lat = (b == 32'd0) ? 2 : 34;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    do begin
      tick();
      n++;
      if (scramble && n < 30 && lat == 34) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        start_i      = 1'($urandom_range(0, 1));
      end else begin
        start_i = 1'b1;
      end
    end while (!ready_o && n < 100);
    check64({tag, " latency"}, 64'(n), 64'(lat));
    check64({tag, " result"}, result_o, exp);
    start_i   = 1'b1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    tick();
    tick();
    check64({tag, " hold ready"}, 64'(ready_o), 64'(1));
    check64({tag, " hold result"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check64({tag, " release ready"}, 64'(ready_o), 64'(0));
    check64({tag, " release result"}, result_o, 64'd0);
    check64({tag, " release state"}, 64'(dbg_state_o), 64'(DivFree));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check64({tag, " reached ready"}, 64'(ready_o), 64'(1));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [63:0] exp_neg;

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check64("reset ready", 64'(ready_o), 64'(0));
    check64("reset result", result_o, 64'd0);
    check64("reset state", 64'(dbg_state_o), 64'(DivFree));
    rst = 1'b1;

    run_div("u7div2", 32'd7, 32'd2, 1'b0, 64'h00000001_00000003, 1'b0);
`ifdef DIV_SIGNED_EN
    exp_neg = 64'hFFFFFFFF_FFFFFFFD;
`else
    exp_neg = 64'h00000001_7FFFFFFC;
`endif
    run_div("s-7div2", 32'hFFFFFFF9, 32'h2, 1'b1, exp_neg, 1'b0);
    run_div("byzero", 32'h1234, 32'h0, 1'b0, 64'd0, 1'b0);
    run_div("minint", 32'h80000000, 32'hFFFFFFFF, 1'b1,
            ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 1'b0);
    run_div("zero_num", 32'h0, 32'h0000_0009, 1'b1, ref_div(32'h0, 32'h9, 1'b1), 1'b0);
    run_div("max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
            ref_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 1'b0);

    // Annul during the iteration phase.
    signed_div_i = 1'b0;
    opdata1_i    = 32'h64;
    opdata2_i    = 32'h7;
    start_i      = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    tick();
    check64("annul_on state", 64'(dbg_state_o), 64'(DivFree));
    check64("annul_on ready", 64'(ready_o), 64'(0));
    check64("annul_on result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check64("annul_on idle ready", 64'(ready_o), 64'(0));
    run_div("after_annul", 32'h64, 32'h7, 1'b0, 64'h00000002_0000000E, 1'b0);

    // Annul while the result is being held.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    tick();
    wait_ready("annul_end");
    annul_i = 1'b1;
    tick();
    check64("annul_end state", 64'(dbg_state_o), 64'(DivFree));
    check64("annul_end result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Asynchronous reset mid-division and while a result is held.
    opdata1_i = 32'h64;
    opdata2_i = 32'h7;
    start_i   = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #2 rst = 1'b0;
    #1;
    check64("rst_mid state", 64'(dbg_state_o), 64'(DivFree));
    check64("rst_mid ready", 64'(ready_o), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    wait_ready("rst_end");
    check64("rst_end pre result", result_o, 64'h00000002_0000000E);
    #2 rst = 1'b0;
    #1;
    check64("rst_end result", result_o, 64'd0);
    check64("rst_end ready", 64'(ready_o), 64'(0));
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    run_div("first_after_rst", 32'd50, 32'd6, 1'b0, ref_div(32'd50, 32'd6, 1'b0), 1'b0);

    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = a >> $urandom_range(0, 31);
        2:       b = ZeroWord - 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), a, b, sg, ref_div(a, b, sg), (i % 2) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
